// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen_if
//  Description : Pixel-coordinate / RGB interface between the raster timing
//                generator (master) and the sprite renderers (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
    logic [9:0] pixel_column;
    logic [9:0] pixel_row;
    logic       video_on;
    logic       horiz_sync;
    logic       vert_sync;
    logic       frame_start;
    logic       red_in;
    logic       green_in;
    logic       blue_in;

    // Timing generator: drives the raster position, consumes the colour.
    modport master (
        output pixel_column, pixel_row, video_on,
        output horiz_sync, vert_sync, frame_start,
        input  red_in, green_in, blue_in
    );

    // Renderer: consumes the raster position, returns the colour.
    modport slave (
        input  pixel_column, pixel_row, video_on,
        input  horiz_sync, vert_sync, frame_start,
        output red_in, green_in, blue_in
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : VGA raster timing generator. Produces pixel row/column,
//                video_on, syncs and frame_start (all registered from the
//                next count) and registers renderer colour to the DAC with
//                blanking applied and syncs delayed to stay pixel-aligned.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  wire logic        clock,
    input  wire logic        reset,
    vga_timing_gen_if.master vif,
    output logic             red_out,
    output logic             green_out,
    output logic             blue_out,
    output logic             vga_hsync,
    output logic             vga_vsync
);

    localparam int c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] c_h_last     = 10'(c_h_total - 1);
    localparam logic [9:0] c_v_last     = 10'(c_v_total - 1);
    localparam logic [9:0] c_h_vis      = 10'(H_VISIBLE);
    localparam logic [9:0] c_v_vis      = 10'(V_VISIBLE);
    localparam logic [9:0] c_hs_first   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] c_hs_last    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] c_vs_first   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] c_vs_last    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic       c_sync_idle  = ~SYNC_POL;

    // Raster counters and registered decodes
    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic       video_on_q, video_on_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       frame_start_q, frame_start_d;

    // DAC output stage
    logic       red_q, green_q, blue_q;
    logic       vga_hsync_q, vga_vsync_q;

    // Next raster position and the decodes for that position, so the
    // registered flags line up with the count they are presented with.
    always_comb begin
        col_d = col_q + 10'd1;
        row_d = row_q;
        if (col_q == c_h_last) begin
            col_d = 10'd0;
            if (row_q == c_v_last) begin
                row_d = 10'd0;
            end else begin
                row_d = row_q + 10'd1;
            end
        end

        video_on_d    = (col_d < c_h_vis) && (row_d < c_v_vis);
        hsync_d       = ((col_d >= c_hs_first) && (col_d <= c_hs_last)) ? SYNC_POL : c_sync_idle;
        vsync_d       = ((row_d >= c_vs_first) && (row_d <= c_vs_last)) ? SYNC_POL : c_sync_idle;
        frame_start_d = (col_d == 10'd0) && (row_d == 10'd0);
    end

    // Raster state register; reset parks the count at (0,0) with all flags idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            col_q         <= 10'd0;
            row_q         <= 10'd0;
            video_on_q    <= 1'b0;
            hsync_q       <= c_sync_idle;
            vsync_q       <= c_sync_idle;
            frame_start_q <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Output stage: colour sampled against the current pixel's video_on and
    // syncs delayed one clock so both describe the same pixel at the DAC.
    always_ff @(posedge clock) begin
        if (reset) begin
            red_q       <= 1'b0;
            green_q     <= 1'b0;
            blue_q      <= 1'b0;
            vga_hsync_q <= c_sync_idle;
            vga_vsync_q <= c_sync_idle;
        end else begin
            red_q       <= vif.red_in   & video_on_q;
            green_q     <= vif.green_in & video_on_q;
            blue_q      <= vif.blue_in  & video_on_q;
            vga_hsync_q <= hsync_q;
            vga_vsync_q <= vsync_q;
        end
    end

    assign vif.pixel_column = col_q;
    assign vif.pixel_row    = row_q;
    assign vif.video_on     = video_on_q;
    assign vif.horiz_sync   = hsync_q;
    assign vif.vert_sync    = vsync_q;
    assign vif.frame_start  = frame_start_q;

    assign red_out   = red_q;
    assign green_out = green_q;
    assign blue_out  = blue_q;
    assign vga_hsync = vga_hsync_q;
    assign vga_vsync = vga_vsync_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Directed self-checking bench for vga_timing_gen. Three
//                instances share clock/reset/colour: default parameters,
//                default horizontal with a short frame, and a tiny raster
//                with active-high syncs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic red = 1'b1, green = 1'b1, blue = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int viol  = 0;
    bit mon_en = 1'b0;

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_timing_gen_if if_d ();
    vga_timing_gen_if if_m ();
    vga_timing_gen_if if_s ();

    assign if_d.red_in = red;  assign if_d.green_in = green;  assign if_d.blue_in = blue;
    assign if_m.red_in = red;  assign if_m.green_in = green;  assign if_m.blue_in = blue;
    assign if_s.red_in = red;  assign if_s.green_in = green;  assign if_s.blue_in = blue;

    logic r_d, g_d, b_d, vh_d, vv_d;
    logic r_m, g_m, b_m, vh_m, vv_m;
    logic r_s, g_s, b_s, vh_s, vv_s;

    vga_timing_gen dut_d (
        .clock(clk), .reset(rst), .vif(if_d),
        .red_out(r_d), .green_out(g_d), .blue_out(b_d),
        .vga_hsync(vh_d), .vga_vsync(vv_d)
    );

    // Full 800-clock lines, 30-line frame (vsync on rows 23..24)
    vga_timing_gen #(
        .V_VISIBLE(20), .V_FRONT(3), .V_SYNC(2), .V_BACK(5)
    ) dut_m (
        .clock(clk), .reset(rst), .vif(if_m),
        .red_out(r_m), .green_out(g_m), .blue_out(b_m),
        .vga_hsync(vh_m), .vga_vsync(vv_m)
    );

    // 8-clock lines, 6-line frame, active-high syncs
    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b1)
    ) dut_s (
        .clock(clk), .reset(rst), .vif(if_s),
        .red_out(r_s), .green_out(g_s), .blue_out(b_s),
        .vga_hsync(vh_s), .vga_vsync(vv_s)
    );

    // Colour must be dark at any pixel whose predecessor was blanked.
    always @(negedge clk) begin
        if (mon_en && (if_m.pixel_row >= 10'd20 || if_m.pixel_column == 10'd0) && (r_m | g_m | b_m))
            viol++;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit at_pos(input int sel, input int c, input int r);
        if (sel == 0) return (int'(if_m.pixel_column) == c) && (int'(if_m.pixel_row) == r);
        return (int'(if_s.pixel_column) == c) && (int'(if_s.pixel_row) == r);
    endfunction

    // sel 0 = medium instance, 1 = small instance; a timeout is a failed check
    task automatic wait_pos(input int sel, input int c, input int r, input int budget, input string tag);
        int k;
        k = 0;
        while (!at_pos(sel, c, r) && k < budget) begin
            tick();
            k++;
        end
        chk_eq(tag, 32'(at_pos(sel, c, r)), 32'd1);
    endtask

    int cyc_rel, t0, n, k;

    initial begin
        // ---------------- reset state ----------------
        repeat (3) tick();
        chk_eq("rst_col_d",   32'(if_d.pixel_column), 0);
        chk_eq("rst_row_d",   32'(if_d.pixel_row),    0);
        chk_eq("rst_von_d",   32'(if_d.video_on),     0);
        chk_eq("rst_fs_d",    32'(if_d.frame_start),  0);
        chk_eq("rst_hs_d",    32'(if_d.horiz_sync),   1);
        chk_eq("rst_vs_d",    32'(if_d.vert_sync),    1);
        chk_eq("rst_rgb_d",   32'({r_d, g_d, b_d}),   0);
        chk_eq("rst_vgas_d",  32'({vh_d, vv_d}),      3);
        chk_eq("rst_syn_s",   32'({if_s.horiz_sync, if_s.vert_sync, vh_s, vv_s}), 0);

        // ---------------- release ----------------
        rst = 1'b0;
        tick();
        cyc_rel = cyc;
        mon_en  = 1'b1;
        chk_eq("rel_col_d",   32'(if_d.pixel_column), 1);
        chk_eq("rel_row_d",   32'(if_d.pixel_row),    0);
        chk_eq("rel_von_d",   32'(if_d.video_on),     1);
        chk_eq("rel_red_d",   32'(r_d),               0);
        chk_eq("rel_col_s",   32'(if_s.pixel_column), 1);
        tick();
        chk_eq("rgb_rise_d",  32'({r_d, g_d, b_d}),   7);

        // ---------------- blanking edge at column 640 ----------------
        wait_pos(0, 639, 0, 1000, "wait_639");
        chk_eq("von_639",     32'(if_m.video_on), 1);
        chk_eq("red_639",     32'(r_m), 1);
        tick();
        chk_eq("von_640",     32'(if_m.video_on), 0);
        chk_eq("von_640_d",   32'(if_d.video_on), 0);
        chk_eq("red_640",     32'(r_m), 1);
        tick();
        chk_eq("red_641",     32'(r_m), 0);

        // ---------------- horizontal sync ----------------
        wait_pos(0, 655, 0, 100, "wait_655");
        chk_eq("hs_655",      32'(if_m.horiz_sync), 1);
        tick();
        t0 = cyc;
        chk_eq("hs_656",      32'(if_m.horiz_sync), 0);
        chk_eq("hs_656_d",    32'(if_d.horiz_sync), 0);
        chk_eq("vgahs_656",   32'(vh_m), 1);
        tick();
        chk_eq("vgahs_657",   32'(vh_m), 0);
        n = 2;
        while (if_m.horiz_sync == 1'b0 && n < 200) begin
            tick();
            if (if_m.horiz_sync == 1'b0) n++;
        end
        chk_eq("hs_width",    32'(n), 96);
        chk_eq("hs_end_col",  32'(if_m.pixel_column), 752);
        chk_eq("vgahs_752",   32'(vh_m), 0);
        tick();
        chk_eq("vgahs_753",   32'(vh_m), 1);

        // ---------------- line wrap and period ----------------
        wait_pos(0, 799, 0, 100, "wait_799");
        tick();
        chk_eq("wrap_col",    32'(if_m.pixel_column), 0);
        chk_eq("wrap_row",    32'(if_m.pixel_row),    1);
        chk_eq("wrap_row_d",  32'(if_d.pixel_row),    1);
        chk_eq("wrap_von",    32'(if_m.video_on),     1);
        wait_pos(0, 656, 1, 1000, "wait_656_r1");
        chk_eq("line_period", 32'(cyc - t0), 800);

        // ---------------- colour alignment ----------------
        blue = 1'b0;
        wait_pos(0, 100, 2, 1000, "wait_100");
        chk_eq("blue_100",    32'(b_m), 0);
        blue = 1'b1;
        tick();
        chk_eq("blue_101",    32'(b_m), 1);
        chk_eq("blue_101_d",  32'(b_d), 1);
        chk_eq("red_101",     32'(r_m), 1);
        blue = 1'b0;
        tick();
        chk_eq("blue_102",    32'(b_m), 0);

        // ---------------- vertical timing (medium instance) ----------------
        wait_pos(0, 0, 20, 20000, "wait_r20");
        chk_eq("von_r20",     32'(if_m.video_on), 0);
        chk_eq("red_r20",     32'(r_m), 0);
        wait_pos(0, 799, 22, 3000, "wait_r22");
        chk_eq("vs_r22",      32'(if_m.vert_sync), 1);
        tick();
        chk_eq("vs_r23",      32'(if_m.vert_sync), 0);
        n = 1;
        while (if_m.vert_sync == 1'b0 && n < 3000) begin
            tick();
            if (if_m.vert_sync == 1'b0) n++;
        end
        chk_eq("vs_width",    32'(n), 1600);
        chk_eq("vs_end_row",  32'(if_m.pixel_row), 25);
        chk_eq("vgavs_lag",   32'(vv_m), 0);
        wait_pos(0, 799, 29, 6000, "wait_r29");
        chk_eq("fs_before",   32'(if_m.frame_start), 0);
        tick();
        chk_eq("fwrap_pos",   32'({if_m.pixel_row, if_m.pixel_column}), 0);
        chk_eq("fs_first",    32'(if_m.frame_start), 1);
        chk_eq("fs_latency",  32'(cyc - cyc_rel), 23999);
        t0 = cyc;
        tick();
        chk_eq("fs_width",    32'(if_m.frame_start), 0);
        k = 0;
        while (if_m.frame_start == 1'b0 && k < 30000) begin
            tick();
            k++;
        end
        chk_eq("frame_period", 32'(cyc - t0), 24000);
        mon_en = 1'b0;
        chk_eq("blank_viol",  32'(viol), 0);

        // ---------------- small raster, active-high syncs ----------------
        wait_pos(1, 3, 0, 100, "s_wait_3");
        chk_eq("s_von_3",     32'(if_s.video_on), 1);
        chk_eq("s_hs_3",      32'(if_s.horiz_sync), 0);
        tick();
        chk_eq("s_von_4",     32'(if_s.video_on), 0);
        chk_eq("s_hs_4",      32'(if_s.horiz_sync), 0);
        tick();
        chk_eq("s_hs_5",      32'(if_s.horiz_sync), 1);
        tick();
        chk_eq("s_hs_6",      32'(if_s.horiz_sync), 1);
        chk_eq("s_vgahs_6",   32'(vh_s), 1);
        tick();
        chk_eq("s_hs_7",      32'(if_s.horiz_sync), 0);
        tick();
        chk_eq("s_wrap",      32'({if_s.pixel_row, if_s.pixel_column}), 32'({10'd1, 10'd0}));
        wait_pos(1, 7, 3, 100, "s_wait_r3");
        chk_eq("s_vs_r3",     32'(if_s.vert_sync), 0);
        tick();
        chk_eq("s_vs_r4",     32'(if_s.vert_sync), 1);
        wait_pos(1, 7, 4, 100, "s_wait_r4e");
        chk_eq("s_vs_r4e",    32'(if_s.vert_sync), 1);
        tick();
        chk_eq("s_vs_r5",     32'(if_s.vert_sync), 0);
        wait_pos(1, 7, 5, 100, "s_wait_last");
        tick();
        chk_eq("s_fs",        32'(if_s.frame_start), 1);
        t0 = cyc;
        tick();
        k = 0;
        while (if_s.frame_start == 1'b0 && k < 200) begin
            tick();
            k++;
        end
        chk_eq("s_frame_period", 32'(cyc - t0), 48);

        // ---------------- mid-frame reset ----------------
        red = 1'b1; green = 1'b1; blue = 1'b1;
        wait_pos(0, 700, 10, 30000, "wait_700_10");
        chk_eq("pre_hs",      32'(if_m.horiz_sync), 0);
        rst = 1'b1;
        tick();
        chk_eq("mrst_pos",    32'({if_m.pixel_row, if_m.pixel_column}), 0);
        chk_eq("mrst_von",    32'(if_m.video_on), 0);
        chk_eq("mrst_fs",     32'(if_m.frame_start), 0);
        chk_eq("mrst_syncs",  32'({if_m.horiz_sync, if_m.vert_sync, vh_m, vv_m}), 15);
        chk_eq("mrst_rgb",    32'({r_m, g_m, b_m}), 0);
        repeat (4) tick();
        chk_eq("hold_pos",    32'({if_m.pixel_row, if_m.pixel_column}), 0);
        chk_eq("hold_flags",  32'({if_m.video_on, if_m.frame_start, r_m, if_m.horiz_sync, vh_m}), 3);
        chk_eq("hold_s_syn",  32'({if_s.horiz_sync, if_s.vert_sync}), 0);
        rst = 1'b0;
        tick();
        chk_eq("mrel_col",    32'(if_m.pixel_column), 1);
        chk_eq("mrel_row",    32'(if_m.pixel_row), 0);
        chk_eq("mrel_von",    32'(if_m.video_on), 1);
        chk_eq("mrel_col_d",  32'(if_d.pixel_column), 1);
        tick();
        chk_eq("mrel_rgb",    32'({r_m, g_m, b_m}), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates VGA 640x480 raster timing from the 25 MHz pixel clock. Drives pixel_row/pixel_column and vert_sync into the sprite renderers (e.g. the player graphic). Also registers their combinational RGB back out to the DAC, with sync delayed to stay pixel-aligned. It is the source end of the pixel-coordinate/RGB interface that the renderers consume.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of both syncs (0 = active-low)

Ports:
clock  input  1  pixel clock, all logic on rising edge
reset  input  1  synchronous, active-high
red_in, green_in, blue_in  input  1 each  renderer colour for current pixel_row/pixel_column
pixel_column  output  10  horizontal count, 0..H_TOTAL-1
pixel_row  output  10  vertical count, 0..V_TOTAL-1
video_on  output  1  high when pixel_column<H_VISIBLE and pixel_row<V_VISIBLE
horiz_sync  output  1  raster-aligned hsync (level SYNC_POL when asserted)
vert_sync  output  1  raster-aligned vsync; clocks sprite motion logic
frame_start  output  1  one-clock pulse when count is (0,0)
red_out, green_out, blue_out  output  1 each  registered, blank-gated colour to DAC
vga_hsync, vga_vsync  output  1 each  horiz_sync/vert_sync delayed one clock, aligned with RGB outputs

Behaviour:
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525). Counters are 10 bits; the parameter sums must not exceed 1024.
- Column counter +1 every clock. At H_TOTAL-1 it wraps to 0, and the row counter +1. Row wraps from V_TOTAL-1 to 0 at the same edge the column wraps.
- horiz_sync, vert_sync, video_on and frame_start are registers. They are computed from the next count, so all are consistent with the pixel_row/pixel_column presented in the same cycle. No decode glitches.
- horiz_sync asserted for columns [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = 656..751.
- vert_sync asserted for rows [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] = 490..491, for entire lines (column 0..799).
- Deasserted sync level is ~SYNC_POL.
- frame_start is high only in the cycle where the count is (0,0).
- Reset (any cycle, including mid-frame): at the edge, counters load (0,0). video_on=0, frame_start=0, horiz_sync=vert_sync=~SYNC_POL. red_out/green_out/blue_out=0, vga_hsync=vga_vsync=~SYNC_POL. These values hold while reset stays high.
- First edge with reset low loads count (1,0) with video_on=1. The first frame_start occurs when the count next reaches (0,0), H_TOTAL*V_TOTAL-1 = 419999 edges after reset release.
- Output stage, 1-clock latency:
  - red_out <= red_in & video_on; same for green and blue.
  - vga_hsync <= horiz_sync; vga_vsync <= vert_sync.
  - RGB and DAC syncs therefore describe the same pixel.
- RGB inputs are sampled every clock. Colour during blanking is always forced to 0, regardless of input.

Test Plan:
- Reset: hold reset 5 clocks mid-frame at count (700,300) -> next cycle pixel_column=0, pixel_row=0, video_on=0, both syncs =1, RGB=0. Release -> (1,0), video_on=1.
- Line timing: after release, horiz_sync falls at pixel_column=656 and stays low 96 clocks. pixel_column wraps 799->0 and pixel_row increments in that cycle. Line period = 800 clocks.
- Frame timing: vert_sync low exactly during rows 490-491 (1600 clocks). pixel_row wraps 524->0. frame_start pulses exactly 1 clock, with successive pulses 420000 clocks apart.
- Blanking gate: red_in=green_in=blue_in=1 constant -> red_out=1 one clock after video_on rises. It falls one clock after video_on falls at column 640, and stays 0 through rows 480-524.
- Alignment: toggle blue_in only when pixel_column=100 -> blue_out=1 in the cycle after. vga_hsync lags horiz_sync by exactly 1 clock.
- Parameter override: H params 4/1/2/1, V params 3/1/1/1, SYNC_POL=1 -> line=8 clocks, frame=48 clocks. hsync high at columns 5-6; vsync high on row 4.
